// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM states, parity encodings and data-length decode for the UART transmitter
// ST_BREAK exists only when UART_TX_BREAK_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
`ifdef UART_TX_BREAK_EN
    ST_STOP,
    ST_BREAK
`else
    ST_STOP
`endif
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // data_len 00..11 selects 5..8 data bits, so the last bit index is 4..7
  localparam logic [2:0] LAST_IDX_BASE = 3'd4;

  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    return LAST_IDX_BASE + {1'b0, len};
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] len,
                                      input logic [1:0] ptype);
    logic [7:0] mask;
    logic       ones_odd;
    mask     = 8'hFF >> (2'd3 - len);
    ones_odd = ^(data & mask);
    case (ptype)
      PAR_ODD:  return ~ones_odd;
      PAR_EVEN: return ones_odd;
      PAR_MARK: return 1'b1;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
// Push is dropped when full and pop is ignored when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_level,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter with configurable framing and baud divisor
// Define UART_TX_BREAK_EN to add the break_req port and the line-break state.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int  FIFO_DEPTH = 16,
  parameter int  DIV_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       data_len,
  input  logic [1:0]       parity_type,
  input  logic             stop_bits,
`ifdef UART_TX_BREAK_EN
  input  logic             break_req,
`endif
  output logic             data_out,
  output logic             tx_active,
  output logic             tx_done,
  output logic [LVL_W-1:0] fifo_level,
  output logic             fifo_empty,
  output logic             fifo_full
);

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_reload_val;
  logic [1:0]       r_len;
  logic [1:0]       r_par;
  logic             r_stop2;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic             r_stop_idx;
  logic             w_stop_idx_next;
  logic             r_data_out;
  logic             w_out_next;
  logic             r_tx_done;
  logic             w_done_next;
  logic             w_tick;
  logic             w_reload;
  logic             w_load_cfg;
  logic             w_pop;
  logic             w_boundary;
  logic [7:0]       w_fifo_rdata;
`ifdef UART_TX_BREAK_EN
  logic             r_brk_tail;
  logic             w_brk_tail_next;
`endif

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .i_push  (s_valid),
    .i_wdata (s_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_level (fifo_level),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign s_ready      = !fifo_full;
  assign w_tick       = (r_baud_cnt == '0);
  assign w_reload_val = w_load_cfg ? divisor : r_div;

  always_comb begin
    w_state_next    = r_state;
    w_pop           = 1'b0;
    w_load_cfg      = 1'b0;
    w_reload        = 1'b0;
    w_boundary      = 1'b0;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_out_next      = r_data_out;
    w_done_next     = 1'b0;
`ifdef UART_TX_BREAK_EN
    w_brk_tail_next = r_brk_tail;
`endif
    case (r_state)
      ST_IDLE: begin
        w_out_next = 1'b1;
        w_boundary = 1'b1;
      end
      ST_START: if (w_tick) begin
        w_state_next   = ST_DATA;
        w_reload       = 1'b1;
        w_bit_idx_next = 3'd0;
        w_out_next     = r_shift[0];
      end
      ST_DATA: if (w_tick) begin
        w_reload = 1'b1;
        if (r_bit_idx == last_bit_idx(r_len)) begin
          w_stop_idx_next = 1'b0;
          if (r_par == PAR_NONE) begin
            w_state_next = ST_STOP;
            w_out_next   = 1'b1;
          end else begin
            w_state_next = ST_PARITY;
            w_out_next   = parity_bit(r_shift, r_len, r_par);
          end
        end else begin
          w_bit_idx_next = r_bit_idx + 3'd1;
          w_out_next     = r_shift[r_bit_idx + 3'd1];
        end
      end
      ST_PARITY: if (w_tick) begin
        w_state_next = ST_STOP;
        w_reload     = 1'b1;
        w_out_next   = 1'b1;
      end
      ST_STOP: if (w_tick) begin
        if (r_stop2 && !r_stop_idx) begin
          w_stop_idx_next = 1'b1;
          w_reload        = 1'b1;
        end else begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
          w_out_next   = 1'b1;
          w_boundary   = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      // the counter is held at reload while low so the trailing high period starts fresh
      ST_BREAK: begin
        if (!r_brk_tail) begin
          w_reload = 1'b1;
          if (break_req) begin
            w_out_next = 1'b0;
          end else begin
            w_out_next      = 1'b1;
            w_brk_tail_next = 1'b1;
          end
        end else if (w_tick) begin
          w_state_next    = ST_IDLE;
          w_brk_tail_next = 1'b0;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase

    if (w_boundary) begin
`ifdef UART_TX_BREAK_EN
      if (break_req) begin
        w_state_next    = ST_BREAK;
        w_load_cfg      = 1'b1;
        w_reload        = 1'b1;
        w_out_next      = 1'b0;
        w_brk_tail_next = 1'b0;
      end else
`endif
      if (!fifo_empty) begin
        w_pop        = 1'b1;
        w_state_next = ST_START;
        w_load_cfg   = 1'b1;
        w_reload     = 1'b1;
        w_out_next   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
      r_div      <= '0;
      r_len      <= '0;
      r_par      <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_data_out <= 1'b1;
      r_tx_done  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_brk_tail <= 1'b0;
`endif
    end else begin
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_data_out <= w_out_next;
      r_tx_done  <= w_done_next;
`ifdef UART_TX_BREAK_EN
      r_brk_tail <= w_brk_tail_next;
`endif
      if (w_reload)     r_baud_cnt <= w_reload_val;
      else if (!w_tick) r_baud_cnt <= r_baud_cnt - 1'b1;
      if (w_load_cfg) begin
        r_div   <= divisor;
        r_len   <= data_len;
        r_par   <= parity_type;
        r_stop2 <= stop_bits;
      end
      if (w_pop) r_shift <= w_fifo_rdata;
    end
  end

  assign data_out  = r_data_out;
  assign tx_done   = r_tx_done;
  assign tx_active = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - bench for uart_tx_fifo: queue-based line model plus literal frame checks
// The break scenario is included when UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int LOGN  = 8192;

  logic          clock = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic [DW-1:0] divisor = '0;
  logic [1:0]    data_len = 2'b11;
  logic [1:0]    parity_type = 2'b00;
  logic          stop_bits = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic          break_req = 1'b0;
`endif
  logic          data_out;
  logic          tx_active;
  logic          tx_done;
  logic [4:0]    fifo_level;
  logic          fifo_empty;
  logic          fifo_full;

  always #5 clock = ~clock;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .clock       (clock),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .divisor     (divisor),
    .data_len    (data_len),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
`ifdef UART_TX_BREAK_EN
    .break_req   (break_req),
`endif
    .data_out    (data_out),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .fifo_level  (fifo_level),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic log_out  [LOGN];
  logic log_done [LOGN];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (cyc < LOGN) begin
      log_out[cyc]  = data_out;
      log_done[cyc] = tx_done;
    end
  end

  // model: FIFO as a queue, the line as a per-cycle list of expected levels
  byte unsigned mq[$];
  logic         ml[$];
  bit           mfinal[$];
  logic         e_out = 1'b1;
  logic         e_done = 1'b0;
  logic         e_act = 1'b0;
  int           e_lvl = 0;
  bit           prev_fin = 1'b0;
  bit           model_en = 1'b0;

  task automatic build_frame(input byte unsigned d);
    int   nb;
    int   reps;
    int   ones;
    logic bits[$];
    nb   = 5 + int'(data_len);
    reps = int'(divisor) + 1;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    case (parity_type)
      2'b01:   bits.push_back((ones % 2) == 0);
      2'b10:   bits.push_back((ones % 2) == 1);
      2'b11:   bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (stop_bits) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (int r = 0; r < reps; r++) begin
        ml.push_back(bits[k]);
        mfinal.push_back((k == bits.size() - 1) && (r == reps - 1));
      end
  endtask

  always @(posedge clock or negedge rst) begin
    bit ready;
    bit fin;
    if (!rst) begin
      mq.delete(); ml.delete(); mfinal.delete();
      e_out = 1'b1; e_done = 1'b0; e_act = 1'b0; e_lvl = 0; prev_fin = 1'b0;
    end else begin
      ready = (mq.size() < DEPTH);
      if (ml.size() == 0 && mq.size() != 0) build_frame(mq.pop_front());
      if (s_valid && ready) mq.push_back(s_data);
      if (ml.size() != 0) begin
        e_out = ml.pop_front();
        fin   = mfinal.pop_front();
        e_act = 1'b1;
      end else begin
        e_out = 1'b1;
        fin   = 1'b0;
        e_act = 1'b0;
      end
      e_done   = prev_fin;
      prev_fin = fin;
      e_lvl    = mq.size();
    end
  end

  always @(negedge clock) begin
    if (model_en && rst) begin
      check("m_data_out", data_out, e_out);
      check("m_tx_done", tx_done, e_done);
      check("m_tx_active", tx_active, e_act);
      check("m_fifo_level", fifo_level, e_lvl);
      check("m_s_ready", s_ready, e_lvl < DEPTH);
      check("m_fifo_empty", fifo_empty, e_lvl == 0);
      check("m_fifo_full", fifo_full, e_lvl == DEPTH);
    end
  end

  task automatic push1(input logic [7:0] d, output int p);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clock);
    p       = cyc;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clock);
    while ((tx_active || !fifo_empty) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_idle timeout got=busy exp=idle");
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p;
    int          dones;
    int          gaps;
    int          n;
    logic [9:0]  v_a5;
    logic [10:0] v_35;
    logic [9:0]  v_5a;

    repeat (3) @(negedge clock);
    check("rst_data_out", data_out, 1);
    check("rst_tx_active", tx_active, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_fifo_full", fifo_full, 0);
    rst = 1'b1;
    model_en = 1'b1;
    @(negedge clock);

    // 8N1, divisor 3, 0xA5
    divisor = 16'd3; data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0;
    push1(8'hA5, p);
    wait_idle(200);
    v_a5 = 10'b1101001010;
    for (int j = 0; j < 40; j++) check("t1_line", log_out[p + 1 + j], v_a5[j / 4]);
    check("t1_done_early", log_done[p + 40], 0);
    check("t1_done_at_40", log_done[p + 41], 1);

    // 7E2, divisor 3, 0x35
    data_len = 2'b10; parity_type = 2'b10; stop_bits = 1'b1;
    push1(8'h35, p);
    wait_idle(200);
    v_35 = 11'b11001101010;
    for (int j = 0; j < 44; j++) check("t2_line", log_out[p + 1 + j], v_35[j / 4]);
    check("t2_done_early", log_done[p + 44], 0);
    check("t2_done_at_44", log_done[p + 45], 1);

    // 17 back-to-back words, divisor 15
    divisor = 16'd15; data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0;
    s_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      s_data = 8'h10 + 8'(k);
      @(negedge clock);
      if (k == 0) p = cyc;
    end
    s_valid = 1'b0;
    check("t3_s_ready", s_ready, 0);
    check("t3_level", fifo_level, 16);
    dones = 0; gaps = 0; n = 0;
    while (dones < 17 && n < 4000) begin
      if (tx_done) dones++;
      else if (!tx_active) gaps++;
      @(negedge clock);
      n++;
    end
    check("t3_dones", dones, 17);
    check("t3_gaps", gaps, 0);
    check("t3_last_done", log_done[p + 1 + 17 * 160], 1);
    wait_idle(100);

    // reset during data bit 3, divisor 0
    divisor = 16'd0;
    push1(8'h00, p);
    push1(8'h81, n);
    repeat (4) @(negedge clock);
    check("t4_pre_rst_line", data_out, 0);
    #1 rst = 1'b0;
    #1;
    check("t4_rst_data_out", data_out, 1);
    check("t4_rst_level", fifo_level, 0);
    check("t4_rst_active", tx_active, 0);
    check("t4_rst_empty", fifo_empty, 1);
    dones = 0;
    repeat (3) begin
      @(negedge clock);
      if (tx_done) dones++;
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (tx_done) dones++;
    end
    check("t4_no_done", dones, 0);
    push1(8'h5A, p);
    wait_idle(100);
    v_5a = 10'b1010110100;
    for (int j = 0; j < 10; j++) check("t4_line", log_out[p + 1 + j], v_5a[j]);
    check("t4_done_at_10", log_done[p + 11], 1);

`ifdef UART_TX_BREAK_EN
    begin
      int b0;
      int lows;
      int highs;
      int brk_dones;
      int k;
      model_en = 1'b0;
      divisor = 16'd3; data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0;
      b0 = cyc;
      break_req = 1'b1;
      repeat (50) @(negedge clock);
      push1(8'hC3, p);
      repeat (49) @(negedge clock);
      break_req = 1'b0;
      repeat (20) @(negedge clock);
      lows = 0;
      brk_dones = 0;
      for (int j = 1; j <= 100; j++) if (log_out[b0 + j] == 1'b0) lows++;
      for (int j = 1; j <= 115; j++) if (log_done[b0 + j]) brk_dones++;
      highs = 0;
      k = b0 + 101;
      while (k < b0 + 115 && log_out[k] == 1'b1) begin
        highs++;
        k++;
      end
      check("brk_low_cycles", lows, 100);
      check("brk_high_min4", highs >= 4, 1);
      check("brk_start_seen", log_out[k], 0);
      check("brk_no_done", brk_dones, 0);
      wait_idle(200);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
